// File: rtl/store_pkg.sv
// Shared encodings and types for the store packing path.
package store_pkg;

  // Store size as encoded on req_op.
  typedef enum logic [1:0] {
    OP_SW  = 2'b00,
    OP_SH  = 2'b01,
    OP_SB  = 2'b10,
    OP_RSV = 2'b11
  } store_op_e;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;

  // One buffered store: word address, lane enables, replicated data.
  typedef struct packed {
    logic [29:0] word;
    logic [3:0]  be;
    logic [31:0] data;
  } store_entry_t;

endpackage

// File: rtl/store_lane_gen.sv
// Combinational lane generator: byte enables, replicated data,
// word-aligned address and a reject flag for a single store request.
module store_lane_gen
  import store_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] data,
  output logic [31:0] word_addr,
  output logic        misalign   // misaligned access or reserved op
);

  assign word_addr = {addr[31:2], 2'b00};

  // Decode size and low address bits into lanes and a reject flag.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    be       = 4'b0000;
    data     = wdata;
    misalign = 1'b0;
    case (store_op_e'(op))
      OP_SW: begin
        be       = BE_WORD;
        misalign = (addr[1:0] != 2'b00);
      end
      OP_SH: begin
        be       = addr[1] ? BE_HALF_HI : BE_HALF_LO;
        data     = {2{wdata[15:0]}};
        misalign = addr[0];
      end
      OP_SB: begin
        be   = 4'b0001 << addr[1:0];
        data = {4{wdata[7:0]}};
      end
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_packer.sv
// Store packer: turns sb/sh/sw requests into word-wide masked writes,
// buffered in a small FIFO, and flags misaligned or reserved stores.
module store_packer
  import store_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  output logic        err_valid,
  output logic [31:0] err_addr
);

  localparam int         PW   = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  store_entry_t  entries [DEPTH];
  store_entry_t  head;

  logic [3:0]  lane_be;
  logic [31:0] lane_data;
  logic [31:0] lane_addr;
  logic        lane_bad;

  logic accept, push, pop;

  store_lane_gen u_lane_gen (
    .op        (req_op),
    .addr      (req_addr),
    .wdata     (req_wdata),
    .be        (lane_be),
    .data      (lane_data),
    .word_addr (lane_addr),
    .misalign  (lane_bad)
  );

  assign req_ready = (count < FULL);
  assign mem_valid = (count != '0);
  assign accept    = req_valid & req_ready;
  // Flush wins over both a new request and a transfer in the same cycle.
  assign push      = accept & ~lane_bad & ~flush;
  assign pop       = mem_valid & mem_ready & ~flush;

  assign head      = entries[rd_ptr];
  assign mem_addr  = {head.word, 2'b00};
  assign mem_be    = head.be;
  assign mem_wdata = head.data;

  // Storage array: written on push only.
  always_ff @(posedge clk) begin
    // NOTE: the entry array is not reset; count gates its visibility, so stale data is never issued.
    if (push) entries[wr_ptr] <= '{word: lane_addr[31:2], be: lane_be, data: lane_data};
  end

  // Pointers, occupancy and error reporting.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      err_valid <= 1'b0;
      err_addr  <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      err_valid <= 1'b0;
    end else begin
      err_valid <= accept & lane_bad;
      if (accept & lane_bad) err_addr <= req_addr;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_store_packer.sv
// Directed bench for store_packer (DEPTH=2): packing, errors, backpressure,
// wrap-around ordering, flush and reset.
module tb_store_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        err_valid;
  logic [31:0] err_addr;

  int checks   = 0;
  int failures = 0;

  store_packer #(.DEPTH(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .err_valid (err_valid),
    .err_addr  (err_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Outputs are sampled and inputs driven on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wd);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; mem_ready = 1'b0;
    idle();
    step(); step();
    check("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
    check("rst_err_valid", {31'b0, err_valid}, 32'd0);
    reset = 1'b1;
    step();
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_err_addr", err_addr, 32'h0);

    // sb to the top byte, memory ready: single beat next cycle.
    mem_ready = 1'b1;
    drive(2'b10, 32'h0000_1003, 32'h0000_00AB);
    step(); idle();
    check("sb_valid", {31'b0, mem_valid}, 32'd1);
    check("sb_addr", mem_addr, 32'h0000_1000);
    check("sb_be", {28'b0, mem_be}, 32'h8);
    check("sb_data", mem_wdata, 32'hABAB_ABAB);
    step();
    check("sb_one_beat", {31'b0, mem_valid}, 32'd0);

    // sb lanes 0..2.
    for (int k = 0; k < 3; k++) begin
      drive(2'b10, 32'h0000_1000 + k, 32'h0000_0055 + k);
      step(); idle();
      check("sbk_be", {28'b0, mem_be}, 32'h1 << k);
      check("sbk_data", mem_wdata, {4{8'(8'h55 + k)}});
      step();
    end

    // Aligned halfword in upper lanes.
    drive(2'b01, 32'h0000_2002, 32'h0000_1234);
    step(); idle();
    check("sh_hi_addr", mem_addr, 32'h0000_2000);
    check("sh_hi_be", {28'b0, mem_be}, 32'hC);
    check("sh_hi_data", mem_wdata, 32'h1234_1234);
    drive(2'b01, 32'h0000_2000, 32'hFFFF_5678);
    step(); idle();
    check("sh_lo_be", {28'b0, mem_be}, 32'h3);
    check("sh_lo_data", mem_wdata, 32'h5678_5678);
    step();

    // Misaligned halfword: error pulse, no beat.
    drive(2'b01, 32'h0000_2001, 32'h0000_1234);
    step(); idle();
    check("shmis_no_beat", {31'b0, mem_valid}, 32'd0);
    check("shmis_err", {31'b0, err_valid}, 32'd1);
    check("shmis_err_addr", err_addr, 32'h0000_2001);
    step();
    check("shmis_pulse_end", {31'b0, err_valid}, 32'd0);
    check("shmis_err_hold", err_addr, 32'h0000_2001);

    // Misaligned word, then reserved op.
    drive(2'b00, 32'h0000_3002, 32'h1111_1111);
    step(); idle();
    check("swmis_err", {31'b0, err_valid}, 32'd1);
    check("swmis_err_addr", err_addr, 32'h0000_3002);
    check("swmis_no_beat", {31'b0, mem_valid}, 32'd0);
    drive(2'b11, 32'h0000_4000, 32'h2222_2222);
    step(); idle();
    check("rsv_err", {31'b0, err_valid}, 32'd1);
    check("rsv_err_addr", err_addr, 32'h0000_4000);
    check("rsv_no_beat", {31'b0, mem_valid}, 32'd0);
    step();

    // Backpressure: third request blocked, in-order drain.
    mem_ready = 1'b0;
    drive(2'b00, 32'h0000_0100, 32'h1111_1111);
    step();
    check("bp_ready1", {31'b0, req_ready}, 32'd1);
    check("bp_head1", mem_addr, 32'h0000_0100);
    drive(2'b00, 32'h0000_0104, 32'h2222_2222);
    step();
    check("bp_full", {31'b0, req_ready}, 32'd0);
    drive(2'b00, 32'h0000_0108, 32'h3333_3333);
    step();
    check("bp_still_full", {31'b0, req_ready}, 32'd0);
    check("bp_head_stable", mem_addr, 32'h0000_0100);
    check("bp_data_stable", mem_wdata, 32'h1111_1111);
    idle(); mem_ready = 1'b1;
    step();
    check("bp_second_addr", mem_addr, 32'h0000_0104);
    check("bp_second_data", mem_wdata, 32'h2222_2222);
    check("bp_ready_back", {31'b0, req_ready}, 32'd1);
    step();
    check("bp_drained", {31'b0, mem_valid}, 32'd0);

    // Full, then simultaneous accept and transfer across pointer wrap.
    mem_ready = 1'b0;
    drive(2'b00, 32'h0000_0200, 32'hA0A0_A0A0);
    step();
    drive(2'b00, 32'h0000_0204, 32'hA1A1_A1A1);
    step();
    check("wr_full", {31'b0, req_ready}, 32'd0);
    mem_ready = 1'b1;
    drive(2'b00, 32'h0000_0208, 32'hA2A2_A2A2);
    step();
    check("wr_one_left", {31'b0, req_ready}, 32'd1);
    check("wr_head_204", mem_addr, 32'h0000_0204);
    check("wr_data_204", mem_wdata, 32'hA1A1_A1A1);
    step();
    check("wr_swap_ready", {31'b0, req_ready}, 32'd1);
    check("wr_head_208", mem_addr, 32'h0000_0208);
    check("wr_data_208", mem_wdata, 32'hA2A2_A2A2);
    mem_ready = 1'b0;
    drive(2'b00, 32'h0000_020C, 32'hA3A3_A3A3);
    step();
    check("wr_full_again", {31'b0, req_ready}, 32'd0);
    check("wr_head_still", mem_addr, 32'h0000_0208);
    idle(); mem_ready = 1'b1;
    step();
    check("wr_head_20c", mem_addr, 32'h0000_020C);
    check("wr_data_20c", mem_wdata, 32'hA3A3_A3A3);
    step();
    check("wr_empty", {31'b0, mem_valid}, 32'd0);

    // Flush with two pending and a request present.
    mem_ready = 1'b0;
    drive(2'b00, 32'h0000_0300, 32'h3030_3030);
    step();
    drive(2'b00, 32'h0000_0304, 32'h3131_3131);
    step();
    flush = 1'b1; mem_ready = 1'b1;
    drive(2'b00, 32'h0000_0308, 32'h3232_3232);
    step();
    check("fl_empty", {31'b0, mem_valid}, 32'd0);
    check("fl_no_err", {31'b0, err_valid}, 32'd0);
    check("fl_ready", {31'b0, req_ready}, 32'd1);
    flush = 1'b0; mem_ready = 1'b0;
    drive(2'b00, 32'h0000_0400, 32'h4444_4444);
    step();
    check("fl_after_addr", mem_addr, 32'h0000_0400);
    check("fl_after_data", mem_wdata, 32'h4444_4444);
    flush = 1'b1;
    drive(2'b01, 32'h0000_2001, 32'h0);
    step();
    check("fl_mis_dropped", {31'b0, err_valid}, 32'd0);
    check("fl_mis_addr_kept", err_addr, 32'h0000_4000);
    check("fl_mis_empty", {31'b0, mem_valid}, 32'd0);
    flush = 1'b0; idle();

    // Reset with entries pending and memory stalled.
    drive(2'b00, 32'h0000_0500, 32'h5555_5555);
    step();
    drive(2'b00, 32'h0000_0504, 32'h6666_6666);
    step();
    check("rs_full", {31'b0, req_ready}, 32'd0);
    idle(); reset = 1'b0;
    step();
    check("rs_mem_valid", {31'b0, mem_valid}, 32'd0);
    check("rs_err_valid", {31'b0, err_valid}, 32'd0);
    check("rs_err_addr", err_addr, 32'h0);
    reset = 1'b1; mem_ready = 1'b1;
    step();
    check("rs_ready", {31'b0, req_ready}, 32'd1);
    step();
    check("rs_nothing_issued", {31'b0, mem_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/store_packer.md
STORE_PACKER -- requirements
Module: store_packer

Interface
REQ-001 Parameter DEPTH, default 2, number of buffered store entries (power of two, >=2).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-low.
REQ-004 flush  input  1  discard all pending stores (pipeline exception/redirect).
REQ-005 req_valid  input  1  store request present from MEM stage.
REQ-006 req_ready  output  1  packer can accept a request this cycle.
REQ-007 req_op  input  2  store size: 00 sw, 01 sh, 10 sb, 11 reserved.
REQ-008 req_addr  input  32  byte address of store.
REQ-009 req_wdata  input  32  register data; low byte/halfword used for sb/sh.
REQ-010 mem_valid  output  1  packed word write presented to data memory.
REQ-011 mem_ready  input  1  data memory accepts the write this cycle.
REQ-012 mem_addr  output  32  word-aligned address, low two bits zero.
REQ-013 mem_be  output  4  byte enables; bit k enables bits 8k+7:8k.
REQ-014 mem_wdata  output  32  lane-replicated write data.
REQ-015 err_valid  output  1  one-cycle pulse: misaligned or reserved store rejected.
REQ-016 err_addr  output  32  req_addr of the rejected store; held until next error.

Function
REQ-017 Request accepted when req_valid & req_ready at a rising edge; write transferred when mem_valid & mem_ready.
REQ-018 req_ready SHALL be 1 iff entry count < DEPTH; no same-cycle pass-through when full.
REQ-019 Packing: sw -> be 1111, data = wdata; sh with addr[1]=0 -> be 0011, addr[1]=1 -> be 1100, data = {2{wdata[15:0]}}; sb with addr[1:0]=k -> be = 1 shifted left k, data = {4{wdata[7:0]}}.
REQ-020 mem_addr SHALL equal {req_addr[31:2], 2'b00} of the head entry.
REQ-021 Misaligned (sw with addr[1:0]!=0, sh with addr[0]=1) or op 11 SHALL be accepted but not enqueued; err_valid=1 the following cycle, err_addr updated.
REQ-022 Latency: an accepted valid store into an empty buffer SHALL drive mem_valid on the next cycle.
REQ-023 Entries SHALL leave in acceptance order (FIFO); head outputs stable while mem_valid & ~mem_ready.
REQ-024 Simultaneous accept and transfer SHALL keep count unchanged; read/write pointers wrap modulo DEPTH.
REQ-025 mem_valid SHALL be 1 iff count > 0; mem_addr/be/wdata are don't-care when mem_valid=0.
REQ-026 flush SHALL empty the buffer at the edge, take priority over a simultaneous accept (request dropped, no error pulse), and suppress a same-cycle transfer from updating state beyond emptying.
REQ-027 Count SHALL never exceed DEPTH nor underflow below 0.

Reset
REQ-028 While reset=0 at a rising edge: count, pointers = 0; mem_valid=0; err_valid=0; err_addr=0; req_ready=1 after release.
REQ-029 Reset mid-operation SHALL discard all buffered entries without issuing them to memory.

Structure
REQ-030 Shared package store_pkg SHALL hold op encodings (OP_SW, OP_SH, OP_SB, OP_RSV) and byte-enable constants (BE_WORD, BE_HALF_LO, BE_HALF_HI).
REQ-031 Combinational sub-module store_lane_gen SHALL compute be, replicated data, aligned address and misalign flag; the FIFO and error register live in store_packer.

Verification
REQ-032 sb addr 0x1003, wdata 0x000000AB, mem_ready=1 -> next cycle mem_addr 0x1000, be 1000, wdata 0xABABABAB, one beat.
REQ-033 sh addr 0x2002, wdata 0x1234 -> be 1100, wdata 0x12341234; sh addr 0x2001 -> no mem beat, err_valid pulse, err_addr 0x2001.
REQ-034 mem_ready=0, three sw requests -> first two accepted, req_ready=0 on third; mem_ready=1 -> writes issued in order, req_ready returns 1.
REQ-035 Full buffer, accept blocked; then one transfer plus new request same cycle -> count stays DEPTH-1 then DEPTH correctly, order preserved across pointer wrap.
REQ-036 Two entries pending, flush=1 with req_valid=1 -> mem_valid=0 next cycle, no error, count 0.
REQ-037 reset=0 asserted with entries pending and mem_ready=0 -> mem_valid=0, err_valid=0, req_ready=1 after release.
